// File: rtl/ula_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ula_muldiv_ctrl
//   ALU control decoder (ALUOp/funct -> ALUControl, Shamt select) extended
//   with a MIPS HI/LO multiply/divide unit.  An iterative engine resolves one
//   bit per cycle (shift-add for multiply, restoring shift-subtract for
//   divide).  The engine runs alongside the main ALU; only instructions that
//   touch HI/LO are stalled while it is busy.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   ALUOp       in   [3:0] operation class from main control
//   funct       in   [5:0] R-type funct field
//   valid       in   instruction in this stage is real (not a bubble)
//   rs_val      in   [WIDTH-1:0] operand A (multiplicand/dividend, MT source)
//   rt_val      in   [WIDTH-1:0] operand B (multiplier/divisor)
//   ALUControl  out  [3:0] ALU operation code (combinational)
//   Shamt       out  shift amount from the shamt field (combinational)
//   md_stall    out  hold the pipeline, HI/LO instruction not accepted
//   mf_en       out  instruction is MFHI/MFLO, writeback selects md_result
//   md_result   out  [WIDTH-1:0] HI for MFHI, LO for MFLO, else 0
//   busy        out  engine running (registered)
//   hi, lo      out  [WIDTH-1:0] architectural HI/LO registers (registered)
// ---------------------------------------------------------------------------
module ula_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       ALUControl,
    output logic             Shamt,
    output logic             md_stall,
    output logic             mf_en,
    output logic [WIDTH-1:0] md_result,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   acc_q;      // product high half / partial remainder
    logic [WIDTH-1:0]   work_q;     // multiplier bits / dividend -> quotient
    logic [WIDTH-1:0]   opb_q;      // multiplicand / divisor magnitude
    logic               is_div_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               rtype_s;
    logic               is_md_s;
    logic               is_muldiv_s;
    logic               md_op_s;
    logic               accept_s;
    logic               load_s;
    logic               step_s;
    logic               fix_s;
    logic               last_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic               ge_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Magnitude of a value; only signed operations take the absolute value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        logic [WIDTH-1:0] m;
        if (sgn && x[WIDTH-1]) begin
            m = -x;
        end else begin
            m = x;
        end
        return m;
    endfunction

    // Classify the instruction as a HI/LO operation and decide acceptance.
    always_comb begin
        rtype_s     = (ALUOp == 4'b1111);
        // MF/MT occupy 0100xx, MULT/DIV family 0110xx.
        is_muldiv_s = (funct[5:2] == 4'b0110);
        is_md_s     = (funct[5:2] == 4'b0100) || is_muldiv_s;
        md_op_s     = valid && rtype_s && is_md_s;
        accept_s    = md_op_s && !busy_q;
        md_stall    = md_op_s && busy_q;
        mf_en       = valid && rtype_s && ((funct == F_MFHI) || (funct == F_MFLO));
    end

    // ALU control decode; independent of the engine state.
    always_comb begin
        ALUControl = 4'b0010;
        Shamt      = 1'b0;
        if (ALUOp == 4'b1111) begin
            case (funct)
                6'b000000: begin ALUControl = 4'b0011; Shamt = 1'b1; end
                6'b000010: begin ALUControl = 4'b0100; Shamt = 1'b1; end
                6'b000011: begin ALUControl = 4'b1101; Shamt = 1'b1; end
                6'b000100: ALUControl = 4'b0011;
                6'b000110: ALUControl = 4'b0100;
                6'b000111: ALUControl = 4'b0101;
                6'b100000: ALUControl = 4'b0010;
                6'b100010: ALUControl = 4'b0110;
                6'b100100: ALUControl = 4'b0000;
                6'b100101: ALUControl = 4'b0001;
                6'b100110: ALUControl = 4'b1011;
                6'b100111: ALUControl = 4'b1100;
                6'b101010: ALUControl = 4'b0111;
                6'b101011: ALUControl = 4'b1111;
                6'b010000, 6'b010001, 6'b010010, 6'b010011,
                6'b011000, 6'b011001, 6'b011010, 6'b011011:
                           ALUControl = 4'b0010;
                default:   ALUControl = 4'b0000;
            endcase
        end else begin
            case (ALUOp)
                4'b0100: ALUControl = 4'b0110;
                4'b0101: ALUControl = 4'b1000;
                4'b1000: ALUControl = 4'b0010;
                4'b1010: ALUControl = 4'b0111;
                4'b1011: ALUControl = 4'b1111;
                4'b1100: ALUControl = 4'b0000;
                4'b1101: ALUControl = 4'b0001;
                4'b1110: ALUControl = 4'b1011;
                default: ALUControl = 4'b0010;
            endcase
        end
    end

    // MFHI/MFLO read port.
    always_comb begin
        if (mf_en && (funct == F_MFHI)) begin
            md_result = hi_q;
        end else if (mf_en) begin
            md_result = lo_q;
        end else begin
            md_result = '0;
        end
    end

    // Engine state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Engine next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && is_muldiv_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Engine control strobes.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        fix_s  = 1'b0;
        case (state_q)
            S_IDLE:  load_s = accept_s && is_muldiv_s;
            S_RUN:   step_s = 1'b1;
            S_FIX:   fix_s  = 1'b1;
            default: load_s = 1'b0;
        endcase
    end

    // One-bit datapath step and final sign correction.
    always_comb begin
        last_s    = (cnt_q == CW'(WIDTH - 1));
        add_s     = work_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};
        shifted_s = {acc_q, work_q[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, opb_q};
        ge_s      = (shifted_s >= {1'b0, opb_q});
        if (is_div_q) begin
            // Remainder follows the dividend sign; with a zero divisor the
            // remainder register ends up holding |rs|, which restores rs_val.
            res_hi_s = neg_a_q ? -acc_q : acc_q;
            if (opb_q == '0) begin
                res_lo_s = {WIDTH{1'b1}};
            end else if (neg_a_q ^ neg_b_q) begin
                res_lo_s = -work_q;
            end else begin
                res_lo_s = work_q;
            end
        end else if (neg_a_q ^ neg_b_q) begin
            {res_hi_s, res_lo_s} = -{acc_q, work_q};
        end else begin
            {res_hi_s, res_lo_s} = {acc_q, work_q};
        end
    end

    // Engine datapath and architectural HI/LO registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            work_q   <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (load_s) begin
                // funct[0]=0 -> signed, funct[1]=1 -> divide.
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                acc_q    <= '0;
                is_div_q <= funct[1];
                neg_a_q  <= !funct[0] && rs_val[WIDTH-1];
                neg_b_q  <= !funct[0] && rt_val[WIDTH-1];
                if (funct[1]) begin
                    work_q <= magnitude(rs_val, !funct[0]);
                    opb_q  <= magnitude(rt_val, !funct[0]);
                end else begin
                    work_q <= magnitude(rt_val, !funct[0]);
                    opb_q  <= magnitude(rs_val, !funct[0]);
                end
            end else if (step_s) begin
                cnt_q <= cnt_q + CW'(1);
                if (is_div_q) begin
                    acc_q  <= ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
                    work_q <= {work_q[WIDTH-2:0], ge_s};
                end else begin
                    {acc_q, work_q} <= {add_s, work_q[WIDTH-1:1]};
                end
            end else if (fix_s) begin
                busy_q <= 1'b0;
                hi_q   <= res_hi_s;
                lo_q   <= res_lo_s;
            end else if (accept_s && (funct == F_MTHI)) begin
                hi_q <= rs_val;
            end else if (accept_s && (funct == F_MTLO)) begin
                lo_q <= rs_val;
            end else begin
                busy_q <= busy_q;
            end
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
